// File: rtl/int2float_pkg.sv
// rtl/int2float_pkg.sv - shared constants for the integer-to-float arbiter slice
// Purpose: IEEE-754 single-precision field widths, integer width and the
//          default channel count used by int2float_arbiter and int_to_float_rne.
// Ports: none (package).
package int2float_pkg;

  localparam int INT_W          = 32;
  localparam int FP_EXP_W       = 8;
  localparam int FP_MAN_W       = 23;
  localparam int FP_BIAS        = 127;
  localparam int FP_W           = 1 + FP_EXP_W + FP_MAN_W;
  localparam int NUM_CH_DEFAULT = 4;

  // Bit position of the leading one needs log2(INT_W) bits.
  localparam int LEAD_W         = $clog2(INT_W);

endpackage

// File: rtl/int_to_float_rne.sv
// rtl/int_to_float_rne.sv - combinational 32-bit signed int to single-precision float, round-to-nearest-even
// Purpose: converts one two's-complement integer into an IEEE-754 binary32 value.
// Ports:
//   int_val   in  INT_W  two's-complement integer
//   float_val out FP_W   IEEE-754 single-precision result
module int_to_float_rne
  import int2float_pkg::*;
(
  input  logic [INT_W-1:0] int_val,
  output logic [FP_W-1:0]  float_val
);

  logic                sign;
  logic [INT_W-1:0]    mag;
  logic [LEAD_W-1:0]   lead;
  logic [INT_W-1:0]    norm;
  logic [FP_MAN_W-1:0] man_trunc;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [FP_MAN_W:0]   man_rnd;
  logic [FP_EXP_W-1:0] exp_val;

  always_comb begin
    sign = int_val[INT_W-1];
    // Unsigned 32-bit magnitude: negating 0x80000000 yields 0x80000000,
    // which read as unsigned is exactly 2^31.
    mag  = sign ? (~int_val + INT_W'(1)) : int_val;

    lead = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (mag[i]) lead = LEAD_W'(i);
    end

    // Left-justify so the leading one sits at bit 31; the 23 bits below it
    // are the mantissa, bit 7 is the guard bit, bits 6:0 form the sticky bit.
    // For magnitudes up to 2^24 the dropped bits are all zero.
    norm      = mag << (LEAD_W'(INT_W - 1) - lead);
    man_trunc = norm[INT_W-2 -: FP_MAN_W];
    guard     = norm[INT_W-2-FP_MAN_W];
    sticky    = |norm[INT_W-3-FP_MAN_W:0];
    round_up  = guard & (sticky | man_trunc[0]);

    // A carry out of the mantissa means it rounded up to 2.0: bump the
    // exponent; the low mantissa bits are already zero in that case.
    man_rnd   = {1'b0, man_trunc} + {{FP_MAN_W{1'b0}}, round_up};
    exp_val   = FP_EXP_W'(FP_BIAS) + FP_EXP_W'(lead) + FP_EXP_W'(man_rnd[FP_MAN_W]);

    if (mag == '0) begin
      float_val = '0;
    end else begin
      float_val = {sign, exp_val, man_rnd[FP_MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/int2float_arbiter.sv
// rtl/int2float_arbiter.sv - round-robin arbiter feeding a two-stage int-to-float pipeline
// Purpose: picks one of NUM_CH integer streams round-robin, converts the
//          integer to IEEE-754 single precision and emits it with its channel.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_axis_tdata      in  NUM_CH*32  per-channel integers, channel i at [32*i +: 32]
//   s_axis_tvalid     in  NUM_CH     per-channel valid
//   s_axis_tready     out NUM_CH     per-channel ready, one-hot or zero
//   m_axis_tdata      out 32         float result
//   m_axis_tuser      out CH_W       source channel of the result
//   m_axis_tvalid     out 1          result valid
//   m_axis_tready     in  1          downstream ready
module int2float_arbiter
  import int2float_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*INT_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]       s_axis_tvalid,
  output logic [NUM_CH-1:0]       s_axis_tready,
  output logic [FP_W-1:0]         m_axis_tdata,
  output logic [CH_W-1:0]         m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant_ch;
  logic             grant_vld;
  int               scan_idx;
  logic [INT_W-1:0] grant_data;
  logic             accept;

  logic             s1_valid;
  logic [INT_W-1:0] s1_data;
  logic [CH_W-1:0]  s1_ch;
  logic             s2_valid;
  logic [FP_W-1:0]  s2_data;
  logic [CH_W-1:0]  s2_ch;
  logic             s1_load;
  logic             s2_load;
  logic [FP_W-1:0]  conv_data;

  // Scan from the highest offset down so the lowest offset from rr_ptr that
  // has tvalid is the one left standing.
  always_comb begin
    grant_ch  = '0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (s_axis_tvalid[scan_idx]) begin
        grant_ch  = CH_W'(scan_idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    s2_load       = !s2_valid || m_axis_tready;
    s1_load       = !s1_valid || s2_load;
    accept        = grant_vld && s1_load && !rst;
    grant_data    = s_axis_tdata[INT_W*int'(grant_ch) +: INT_W];
    s_axis_tready = '0;
    if (accept) s_axis_tready[grant_ch] = 1'b1;
  end

  int_to_float_rne u_conv (
    .int_val   (s1_data),
    .float_val (conv_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ch    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ch    <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= grant_data;
          s1_ch   <= grant_ch;
        end
      end
      // Payload only moves with a valid item so a drained stage keeps its
      // last value instead of picking up the converted bubble.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= conv_data;
          s2_ch   <= s1_ch;
        end
      end
    end
  end

  assign m_axis_tvalid = s2_valid;
  assign m_axis_tdata  = s2_data;
  assign m_axis_tuser  = s2_ch;

endmodule

// File: tb/tb_int2float_arbiter.sv
// tb/tb_int2float_arbiter.sv - self-checking bench for int2float_arbiter
module tb_int2float_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [31:0]     m_tdata;
  logic [1:0]      m_tuser;
  logic            m_tvalid;
  logic            m_tready;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          ch;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    int          ch;
    logic [31:0] d;
  } item_t;

  vec_t  tbl[12];
  item_t exp_q[$];

  int          rr_start;
  int          wait_cnt[N];
  int          max_wait;
  int          transfers;
  int          cycles;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [1:0]  prev_user;

  int2float_arbiter #(.NUM_CH(N), .CH_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference conversion from plain integer arithmetic.
  function automatic logic [31:0] ref_conv(input logic [31:0] v);
    longint m, q, r, half;
    int     e;
    logic   s;
    s = v[31];
    m = longint'(signed'(v));
    if (m < 0) m = -m;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e > 23) begin
      q    = m >> (e - 23);
      r    = m - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (r > half || (r == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end else begin
      q = m << (23 - e);
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 40)) - 32'd20;
      2: begin
        v = (32'd1 << $urandom_range(24, 30)) + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      3: v = 32'h8000_0000;
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h7FFF_FFFF;
          1: v = 32'hFFFF_FFFF;
          2: v = 32'h0100_0001;
          default: v = 32'h0;
        endcase
      end
    endcase
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    s_tvalid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Output-side scoreboard for the random phase, run at the negative edge.
  task automatic out_side();
    item_t e;
    if (prev_stall) begin
      check("rnd_hold_valid", m_tvalid, 1);
      check("rnd_hold_data", m_tdata, prev_data);
      check("rnd_hold_user", m_tuser, prev_user);
    end
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_output", m_tvalid, 0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_data", m_tdata, ref_conv(e.d));
        check("rnd_user", m_tuser, 32'(e.ch));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_user  = m_tuser;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] vmask;
    logic [31:0]  held_d;
    logic [1:0]   held_u;
    logic         held_v;
    int           acc, outs, expch, qsize;
    logic [31:0]  bp_din[3];

    tbl[0]  = '{0, 32'h0000_0001, 32'h3F80_0000};
    tbl[1]  = '{0, 32'hFFFF_FFFF, 32'hBF80_0000};
    tbl[2]  = '{0, 32'h0000_0000, 32'h0000_0000};
    tbl[3]  = '{1, 32'h7FFF_FFFF, 32'h4F00_0000};
    tbl[4]  = '{1, 32'h8000_0000, 32'hCF00_0000};
    tbl[5]  = '{1, 32'h0100_0001, 32'h4B80_0000};
    tbl[6]  = '{1, 32'h0100_0003, 32'h4B80_0002};
    tbl[7]  = '{2, 32'h0100_0000, 32'h4B80_0000};
    tbl[8]  = '{2, 32'h0000_0003, 32'h4040_0000};
    tbl[9]  = '{3, 32'hFEFF_FFFE, 32'hCB80_0001};
    tbl[10] = '{3, 32'h0200_0003, 32'h4C00_0001};
    tbl[11] = '{3, 32'hFFFF_FF80, 32'hC300_0000};

    // Reset state, with every channel requesting during reset.
    rst      = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '1;
    s_tdata  = {32'd4, 32'd3, 32'd2, 32'd1};
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_s_tready", s_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tdata", m_tdata, 0);
    check("reset_m_tuser", m_tuser, 0);
    @(posedge clk); #1;
    s_tvalid = '0;
    rst      = 1'b0;

    // Table-driven conversions, one transfer at a time, checking latency.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      s_tvalid                    = '0;
      s_tvalid[tbl[i].ch]         = 1'b1;
      s_tdata[tbl[i].ch*32 +: 32] = tbl[i].din;
      m_tready                    = 1'b1;
      @(negedge clk);
      check("tbl_ready", s_tready, 32'(1 << tbl[i].ch));
      @(posedge clk); #1;
      s_tvalid = '0;
      check("tbl_early", m_tvalid, 0);
      @(posedge clk); #1;
      check("tbl_valid", m_tvalid, 1);
      check("tbl_data", m_tdata, tbl[i].dout);
      check("tbl_user", m_tuser, 32'(tbl[i].ch));
    end

    // All channels valid continuously: grants rotate 0,1,2,3,...
    do_reset();
    s_tdata  = {32'd400, 32'd300, 32'd200, 32'd100};
    s_tvalid = '1;
    m_tready = 1'b1;
    outs     = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rr_grant", s_tready, 32'(1 << (c % 4)));
      if (m_tvalid) begin
        check("rr_tuser", m_tuser, 32'(outs % 4));
        check("rr_data", m_tdata, ref_conv(32'((outs % 4 + 1) * 100)));
        outs++;
      end
      @(posedge clk); #1;
    end
    check("rr_count", outs, 10);

    // Backpressure: three requesters, downstream stalled for five cycles.
    do_reset();
    bp_din   = '{32'hFFFF_F000, 32'h0123_4567, 32'h7FFF_FFC0};
    s_tdata  = {32'd0, bp_din[2], bp_din[1], bp_din[0]};
    s_tvalid = 4'b0111;
    m_tready = 1'b0;
    acc      = 0;
    held_v   = 1'b0;
    held_d   = '0;
    held_u   = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        if (held_v) begin
          check("bp_hold_data", m_tdata, held_d);
          check("bp_hold_user", m_tuser, held_u);
        end
        held_d = m_tdata;
        held_u = m_tuser;
        held_v = 1'b1;
      end
      g = s_tvalid & s_tready;
      acc += $countones(g);
      @(posedge clk); #1;
      s_tvalid = s_tvalid & ~g;
    end
    check("bp_accepted", acc, 2);
    check("bp_out_valid", m_tvalid, 1);
    m_tready = 1'b1;
    outs     = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        if (outs < 3) begin
          check("bp_order_data", m_tdata, ref_conv(bp_din[outs]));
          check("bp_order_user", m_tuser, 32'(outs));
        end
        outs++;
      end
      g = s_tvalid & s_tready;
      @(posedge clk); #1;
      s_tvalid = s_tvalid & ~g;
    end
    check("bp_delivered", outs, 3);

    // Reset with both stages full discards everything; search restarts at 0.
    do_reset();
    s_tdata  = {32'd33, 32'd22, 32'd11, 32'd7};
    s_tvalid = 4'b0011;
    m_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      g = s_tvalid & s_tready;
      @(posedge clk); #1;
      s_tvalid = s_tvalid & ~g;
    end
    check("rst_full_valid", m_tvalid, 1);
    rst      = 1'b1;
    s_tvalid = '1;
    @(negedge clk);
    check("rst_no_accept", s_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    s_tvalid = 4'b1001;
    m_tready = 1'b1;
    @(negedge clk);
    check("rst_first_grant", s_tready, 32'b0001);
    @(posedge clk); #1;
    s_tvalid = '0;
    outs     = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_tvalid) begin
        check("rst_out_user", m_tuser, 0);
        check("rst_out_data", m_tdata, ref_conv(32'd7));
        outs++;
      end
      @(posedge clk); #1;
    end
    check("rst_flush_count", outs, 1);

    // Randomised traffic against the reference model.
    do_reset();
    exp_q.delete();
    rr_start   = 0;
    max_wait   = 0;
    transfers  = 0;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_user  = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    s_tvalid = '0;
    m_tready = 1'b1;
    while (transfers < 10000 && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      qsize = exp_q.size();
      out_side();
      g = s_tvalid & s_tready;
      // With nothing or one item in flight, or the output draining, a
      // requester must be served this cycle.
      check("rnd_ready_any", 32'(g != 0), 32'((s_tvalid != 0) && (qsize < 2 || m_tready)));
      if (g != 0) begin
        expch = -1;
        for (int k = 0; k < N; k++) begin
          if (expch < 0 && s_tvalid[(rr_start + k) % N]) expch = (rr_start + k) % N;
        end
        check("rnd_grant", g, 32'(1 << expch));
        exp_q.push_back('{expch, s_tdata[expch*32 +: 32]});
        rr_start = (expch + 1) % N;
        for (int ch = 0; ch < N; ch++) begin
          if (ch == expch) begin
            wait_cnt[ch] = 0;
          end else if (s_tvalid[ch]) begin
            wait_cnt[ch]++;
            if (wait_cnt[ch] > max_wait) max_wait = wait_cnt[ch];
          end
        end
        transfers++;
      end
      vmask = s_tvalid & ~g;
      @(posedge clk); #1;
      m_tready = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < N; ch++) begin
        if (!vmask[ch]) begin
          s_tvalid[ch]          = ($urandom_range(0, 2) != 0);
          s_tdata[ch*32 +: 32]  = rand_val();
        end
      end
    end
    check("rnd_transfer_budget", 32'(transfers >= 10000), 1);
    check("rnd_starvation", 32'(max_wait <= N - 1), 1);
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      out_side();
      @(posedge clk); #1;
    end
    check("rnd_drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
